iter_div: RTL

Iterative radix-2 restoring divider that executes RV32M DIV, DIVU, REM and REMU. It sits behind the execute-stage ALU and receives one operation per `start` pulse. It holds `busy` while it computes and returns a registered `result` with a one-cycle `done` strobe. The ALU's stall counter is sized to this block's fixed latency.

---
 rtl/iter_div_if.sv | 20 ++
 rtl/iter_div.sv | 128 ++++++++++++
 2 files changed

// File: rtl/iter_div_if.sv
// Request/response bundle for the iterative divider.
interface iter_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] left_operand;
    logic [31:0] right_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, left_operand, right_operand,
        input  busy, done, result
    );

    modport slave (
        input  start, op, left_operand, right_operand,
        output busy, done, result
    );
endinterface

// File: rtl/iter_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with fixed 34-cycle latency.
// Define ITER_DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module iter_div (
    input logic       clk,
    input logic       rst,
    iter_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        is_rem;
    logic        neg_q, neg_r, dz, ovf;
    logic [31:0] rem, quo, divisor, dividend_orig;
    logic [31:0] result_q;
    logic        done_q;

    logic        in_signed, left_neg, right_neg, start_dz, start_ovf;
    logic [31:0] left_abs, right_abs;
    logic [32:0] rem_sh, trial;
    logic        trial_ge;
    logic [31:0] rem_next, quo_next, fix_result;

    always_comb begin
        in_signed = ~bus.op[0];
        left_neg  = in_signed & bus.left_operand[31];
        right_neg = in_signed & bus.right_operand[31];
        left_abs  = left_neg  ? -bus.left_operand  : bus.left_operand;
        right_abs = right_neg ? -bus.right_operand : bus.right_operand;
        start_dz  = (bus.right_operand == '0);
        start_ovf = in_signed && (bus.left_operand == 32'h8000_0000) && (bus.right_operand == '1);
    end

    // Shifted partial remainder is 33 bits wide: it can reach 2*divisor-1.
    always_comb begin
        rem_sh   = {rem, quo[31]};
        trial    = rem_sh - {1'b0, divisor};
        trial_ge = (rem_sh >= {1'b0, divisor});
        rem_next = trial_ge ? trial[31:0] : rem_sh[31:0];
        quo_next = {quo[30:0], trial_ge};
    end

    always_comb begin
        fix_result = '0;
        if (dz)
            fix_result = is_rem ? dividend_orig : '1;
        else if (ovf)
            fix_result = is_rem ? '0 : 32'h8000_0000;
        else if (is_rem)
            fix_result = neg_r ? -rem : rem;
        else
            fix_result = neg_q ? -quo : quo;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef ITER_DIV_EARLY_OUT_EN
                    state_next = (start_dz || start_ovf) ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            is_rem        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            ovf           <= 1'b0;
            rem           <= '0;
            quo           <= '0;
            divisor       <= '0;
            dividend_orig <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt           <= '0;
                        is_rem        <= bus.op[1];
                        neg_q         <= left_neg ^ right_neg;
                        neg_r         <= left_neg;
                        dz            <= start_dz;
                        ovf           <= start_ovf;
                        rem           <= '0;
                        quo           <= left_abs;
                        divisor       <= right_abs;
                        dividend_orig <= bus.left_operand;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
